// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_pkg
// Description : Shared types and constants for the LFSR period-measurement
//               controller and its neighbours in the integration top.
// Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    // Widest LFSR the controller is expected to measure.
    localparam int LFSR_MAX_N = 8;

    // Controller states; explicit 3-bit encoding keeps the register width fixed.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_WAIT = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } lfsr_ctrl_state_t;

endpackage : lfsr_pkg
`default_nettype wire

// File: rtl/lfsr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_ctrl
// Description : Loads a seed into a neighbouring LFSR, then counts steps until
//               the reference value reappears, reporting the cycle length,
//               whether it is maximal, an all-zero seed, or a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_ctrl
    import lfsr_pkg::*;
#(
    parameter int N = 4                // LFSR width, legal 2..LFSR_MAX_N
) (
    input  logic         clk,
    input  logic         reset,        // asynchronous, active low
    input  logic         start,
    input  logic [N-1:0] seed,
    input  logic [N-1:0] lfsr_data,
    output logic         load_seed,
    output logic [N-1:0] seed_data,
    output logic         busy,
    output logic         done,
    output logic [N:0]   period,
    output logic         maximal,
    output logic         stuck_zero,
    output logic         timeout
);

    // Step budget: a repeat must be seen by the time cnt reaches 2^N.
    localparam logic [N:0] c_CNT_LIMIT  = (N+1)'(2**N);
    localparam logic [N:0] c_MAX_PERIOD = (N+1)'(2**N - 1);
    localparam logic [N:0] c_CNT_ONE    = (N+1)'(1);

    lfsr_ctrl_state_t r_state;
    lfsr_ctrl_state_t w_next_state;

    logic [N-1:0] r_seed;
    logic [N-1:0] r_ref;
    logic [N:0]   r_cnt;
    logic [N:0]   r_period;
    logic         r_maximal;
    logic         r_stuck_zero;
    logic         r_timeout;

    logic         w_accept;
    logic         w_match;
    logic         w_limit;

    // Next-state decode plus the state-derived handshake outputs.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_match      = (lfsr_data == r_ref);
        w_limit      = (r_cnt == c_CNT_LIMIT);
        load_seed    = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_seed    = 1'b1;
                busy         = 1'b1;
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                busy         = 1'b1;
                w_next_state = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                // A match wins over the limit so a full-length period still
                // reports as a match on its last permitted step.
                if (w_match || w_limit) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_LOAD;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register, captured seed, reference, step counter and results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_seed       <= '0;
            r_ref        <= '0;
            r_cnt        <= '0;
            r_period     <= '0;
            r_maximal    <= 1'b0;
            r_stuck_zero <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_seed       <= seed;
                r_period     <= '0;
                r_maximal    <= 1'b0;
                r_stuck_zero <= 1'b0;
                r_timeout    <= 1'b0;
            end
            if (r_state == ST_WAIT) begin
                // The LFSR was loaded on the previous edge, so it shows the
                // seed now; that value becomes the reference to look for.
                r_ref        <= lfsr_data;
                r_cnt        <= c_CNT_ONE;
                r_stuck_zero <= (lfsr_data == '0);
            end
            if (r_state == ST_RUN) begin
                if (w_match) begin
                    r_period  <= r_cnt;
                    r_maximal <= (r_cnt == c_MAX_PERIOD);
                end else if (w_limit) begin
                    r_timeout <= 1'b1;
                    r_period  <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
            end
        end
    end

    assign seed_data  = r_seed;
    assign period     = r_period;
    assign maximal    = r_maximal;
    assign stuck_zero = r_stuck_zero;
    assign timeout    = r_timeout;

endmodule : lfsr_ctrl
`default_nettype wire

// File: tb/tb_lfsr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_ctrl
// Description : Directed self-checking bench for lfsr_ctrl, paired with a
//               4-bit x^4+x^3+1 LFSR or with a bench-driven data pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_ctrl;

    localparam int N = 4;

    logic         clk;
    logic         reset;
    logic         start;
    logic [N-1:0] seed;
    logic [N-1:0] lfsr_data;
    logic         load_seed;
    logic [N-1:0] seed_data;
    logic         busy;
    logic         done;
    logic [N:0]   period;
    logic         maximal;
    logic         stuck_zero;
    logic         timeout;

    logic         use_model;
    logic [N-1:0] r_lfsr;
    logic [N-1:0] forced_data;

    int n_assert = 0;
    int n_fail   = 0;
    int n_cyc;
    int n_loads;

    lfsr_ctrl #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .seed       (seed),
        .lfsr_data  (lfsr_data),
        .load_seed  (load_seed),
        .seed_data  (seed_data),
        .busy       (busy),
        .done       (done),
        .period     (period),
        .maximal    (maximal),
        .stuck_zero (stuck_zero),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream LFSR: Fibonacci x^4+x^3+1, maximal for non-zero seeds, stuck at 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         r_lfsr <= '0;
        else if (load_seed) r_lfsr <= seed_data;
        else                r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
    end

    assign lfsr_data = use_model ? r_lfsr : forced_data;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge; afterwards the controller should be in LOAD.
    task automatic start_run(input logic [N-1:0] s);
        seed  = s;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Runs until done (bounded). With use_model=0 the data pattern shows ref_val
    // in WAIT and again on RUN step match_k (0 = never). At cycle dist_n a
    // start pulse with seed=0 is injected to probe that busy ignores it.
    task automatic wait_done(input logic [N-1:0] ref_val, input int match_k,
                             input int dist_n, output int n, output int loads);
        n     = 0;
        loads = 0;
        while (!done && n < 40) begin
            if (n == 1 || (match_k > 0 && n == 1 + match_k)) forced_data = ref_val;
            else forced_data = ref_val ^ ((n % 2) ? 4'h1 : 4'h2);
            if (n == dist_n) begin
                start = 1'b1;
                seed  = 4'h0;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
            if (load_seed) loads++;
        end
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        seed        = '0;
        use_model   = 1'b1;
        forced_data = '0;
        tick();
        tick();

        // Reset state
        check("rst_busy",      busy,       1'b0);
        check("rst_done",      done,       1'b0);
        check("rst_load",      load_seed,  1'b0);
        check("rst_period",    period,     5'd0);
        check("rst_flags",     {maximal, stuck_zero, timeout}, 3'b000);
        check("rst_seed_data", seed_data,  4'h0);
        reset = 1'b1;
        tick();

        // Maximal sequence from seed 0001
        start_run(4'h1);
        check("m1_load",   load_seed, 1'b1);
        check("m1_busy",   busy,      1'b1);
        check("m1_sdata",  seed_data, 4'h1);
        wait_done(4'h0, 0, -1, n_cyc, n_loads);
        check("m1_latency", n_cyc,   17);
        check("m1_loads",   n_loads, 0);
        check("m1_period",  period,  5'd15);
        check("m1_flags",   {maximal, stuck_zero, timeout, busy}, 4'b1000);

        // Results hold in DONE
        tick(); tick(); tick();
        check("hold_done",   done,   1'b1);
        check("hold_period", period, 5'd15);
        check("hold_max",    maximal, 1'b1);

        // New start from DONE with all-zero seed
        start_run(4'h0);
        check("d2_done",   done,      1'b0);
        check("d2_busy",   busy,      1'b1);
        check("d2_load",   load_seed, 1'b1);
        check("d2_clear",  {period, maximal}, 6'd0);
        wait_done(4'h0, 0, -1, n_cyc, n_loads);
        check("z_latency", n_cyc,   3);
        check("z_loads",   n_loads, 0);
        check("z_period",  period,  5'd1);
        check("z_flags",   {maximal, stuck_zero, timeout}, 3'b010);

        // Bench-driven data: short repeat after 3 steps
        use_model = 1'b0;
        start_run(4'h7);
        wait_done(4'h7, 3, -1, n_cyc, n_loads);
        check("p3_latency", n_cyc,  5);
        check("p3_period",  period, 5'd3);
        check("p3_flags",   {maximal, stuck_zero, timeout}, 3'b000);

        // Bench-driven data that never repeats the reference
        start_run(4'h5);
        wait_done(4'h5, 0, -1, n_cyc, n_loads);
        check("to_latency", n_cyc,  18);
        check("to_period",  period, 5'd0);
        check("to_flags",   {maximal, stuck_zero, timeout}, 3'b001);
        use_model = 1'b1;

        // start and seed change during RUN are ignored
        start_run(4'h1);
        wait_done(4'h0, 0, 6, n_cyc, n_loads);
        check("ig_latency", n_cyc,     17);
        check("ig_loads",   n_loads,   0);
        check("ig_period",  period,    5'd15);
        check("ig_max",     maximal,   1'b1);
        check("ig_sdata",   seed_data, 4'h1);

        // Reset at RUN step 5 aborts the run
        start_run(4'h1);
        for (int i = 0; i < 6; i++) tick();
        check("mid_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("ar_busy",   busy,      1'b0);
        check("ar_done",   done,      1'b0);
        check("ar_load",   load_seed, 1'b0);
        check("ar_period", period,    5'd0);
        check("ar_flags",  {maximal, stuck_zero, timeout}, 3'b000);
        check("ar_sdata",  seed_data, 4'h0);
        tick();
        reset = 1'b1;
        tick();
        check("post_idle", {busy, done}, 2'b00);
        start_run(4'h8);
        wait_done(4'h0, 0, -1, n_cyc, n_loads);
        check("r8_latency", n_cyc,  17);
        check("r8_period",  period, 5'd15);
        check("r8_flags",   {maximal, stuck_zero, timeout}, 3'b100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_lfsr_ctrl
`default_nettype wire

// File: doc/lfsr_ctrl.md
LFSR_CTRL -- requirements
Module: lfsr_ctrl

Interface
REQ-001 Parameter N, default 4, meaning LFSR width in bits; legal range 2..8.
REQ-002 clk  input  1  the single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to run a period measurement; sampled only in IDLE or DONE.
REQ-005 seed  input  N  seed value, captured when start is accepted.
REQ-006 lfsr_data  input  N  current register value from the downstream lfsr instance.
REQ-007 load_seed  output  1  drives lfsr load_seed.
REQ-008 seed_data  output  N  drives lfsr seed_data; equals the captured seed.
REQ-009 busy  output  1  high in LOAD, WAIT and RUN.
REQ-010 done  output  1  high while in DONE; results are valid only while done=1.
REQ-011 period  output  N+1  measured cycle length of the sequence.
REQ-012 maximal  output  1  period == 2^N-1.
REQ-013 stuck_zero  output  1  the reference value was all zeros.
REQ-014 timeout  output  1  no repeat was seen within 2^N steps.

Function
REQ-015 States: IDLE, LOAD, WAIT, RUN, DONE.
REQ-016 IDLE or DONE with start=1 -> LOAD; capture seed into seed_reg; clear period, maximal, stuck_zero and timeout.
REQ-017 LOAD lasts exactly 1 cycle with load_seed=1, then goes to WAIT; load_seed=0 in every other state.
REQ-018 WAIT lasts 1 cycle (lfsr_data equals seed here): ref<=lfsr_data, cnt<=1, stuck_zero<=(lfsr_data==0), then -> RUN.
REQ-019 RUN, each cycle: if lfsr_data==ref, then period<=cnt and -> DONE; else if cnt==2^N, then timeout<=1, period<=0 and -> DONE; else cnt<=cnt+1.
REQ-020 cnt is N+1 bits wide and never wraps; it is not updated outside WAIT and RUN.
REQ-021 maximal<=1 on entry to DONE only when the exit was a match with cnt==2^N-1; otherwise it stays 0.
REQ-022 DONE holds every result output stable until start or reset.
REQ-023 start while busy=1 is ignored, with no effect on state or results.
REQ-024 seed_data=seed_reg at all times, so a change on seed mid-run has no effect.
REQ-025 The match compare in RUN is combinational on lfsr_data; an exit happens at most one cycle after the repeat value appears.
REQ-026 Total latency from start accepted to done=1 is period+2 cycles on a match, and 2^N+2 cycles on a timeout.

Reset
REQ-027 reset low -> state IDLE; seed_reg, ref and cnt cleared to 0; load_seed, busy, done, maximal, stuck_zero and timeout set to 0; period set to 0.
REQ-028 Reset in any state, including mid-RUN, aborts immediately; no partial result is presented after release.
REQ-029 The first start after reset release behaves identically to the first start after power-up.

Structure
REQ-030 Shared package lfsr_pkg holds the state enum lfsr_ctrl_state_t and constant LFSR_MAX_N=8.
REQ-031 No sub-module is instantiated; the lfsr instance sits beside lfsr_ctrl in the integration top, wired load_seed->load_seed, seed_data->seed_data, lfsr_data->lfsr_data, with clk and reset shared.
REQ-032 One always_ff block holds the state and registers, and one always_comb block holds next-state logic; there are no latches.

Verification
REQ-033 Integrated with the N=4 lfsr, seed=4'b0001, start pulse -> done after 17 cycles; period=15, maximal=1, timeout=0, stuck_zero=0.
REQ-034 Integrated, seed=4'b0000 -> period=1, stuck_zero=1, maximal=0, done 3 cycles after start.
REQ-035 Bench drives lfsr_data with a sequence that never repeats ref -> timeout=1, period=0, done 18 cycles after start.
REQ-036 Reset asserted for 1 cycle at RUN cycle 5 -> all outputs 0 and state IDLE; a new start with seed=4'b1000 then gives period=15.
REQ-037 start pulsed again during RUN, with seed changed to 4'b0000 -> both ignored; results match the original seed.
REQ-038 In DONE, start with a new seed -> results clear on the next cycle, busy=1, and load_seed pulses exactly once.
